// File: rtl/sd_cmd_response_rx.sv
// SD CMD-line response receiver: waits for the card's start bit, shifts in a
// 48- or 136-bit frame, and reports CRC7, framing and timeout status.
module sd_cmd_response_rx #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic         long_resp,
  input  logic         serial_in,
  output logic         pad_enable,
  output logic         pad_output_input,
  output logic [135:0] response,
  output logic         busy,
  output logic         done,
  output logic         crc_ok,
  output logic         frame_err,
  output logic         timeout
);

  localparam int unsigned TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    WARMUP,
    WAIT_START,
    RECEIVE,
    DONE
  } state_e;

  state_e         state_q;
  logic           long_q;
  logic [7:0]     bit_cnt_q;
  logic [TW-1:0]  to_cnt_q;
  logic [6:0]     crc_q;
  logic [135:0]   resp_q;
  logic           crc_ok_q;
  logic           frame_err_q;
  logic           timeout_q;
  logic           busy_q;
  logic           pad_en_q;
  logic           done_q;

  logic [135:0]   resp_d;
  logic [6:0]     crc_d;
  logic [7:0]     last_bit;
  logic           crc_en;
  logic           crc_ok_d;
  logic           frame_err_d;

  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = c[6] ^ b;
    return {c[5:3], c[2] ^ fb, c[1:0], fb};
  endfunction

  // bit_cnt_q is the index (from the first bit) of the bit arriving this cycle.
  always_comb begin
    resp_d      = {resp_q[134:0], serial_in};
    last_bit    = long_q ? 8'd135 : 8'd47;
    crc_en      = long_q ? ((bit_cnt_q >= 8'd8) && (bit_cnt_q <= 8'd127))
                         : (bit_cnt_q <= 8'd39);
    crc_d       = crc_en ? crc7_step(crc_q, serial_in) : crc_q;
    crc_ok_d    = (crc_q == resp_d[7:1]);
    frame_err_d = long_q ? (resp_d[134] | ~resp_d[0]) : (resp_d[46] | ~resp_d[0]);
  end

  // NOTE: the response register is reset along with the control state because
  // it is a visible output that must read zero after reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      long_q      <= 1'b0;
      bit_cnt_q   <= '0;
      to_cnt_q    <= '0;
      crc_q       <= '0;
      resp_q      <= '0;
      crc_ok_q    <= 1'b0;
      frame_err_q <= 1'b0;
      timeout_q   <= 1'b0;
      busy_q      <= 1'b0;
      pad_en_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            long_q      <= long_resp;
            bit_cnt_q   <= '0;
            to_cnt_q    <= '0;
            crc_q       <= '0;
            resp_q      <= '0;
            crc_ok_q    <= 1'b0;
            frame_err_q <= 1'b0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b1;
            pad_en_q    <= 1'b1;
            state_q     <= WARMUP;
          end
        end
        WARMUP: state_q <= WAIT_START;
        WAIT_START: begin
          // The start bit is zero, so shifting it into a zero CRC leaves it zero.
          if (!serial_in) begin
            resp_q    <= resp_d;
            bit_cnt_q <= 8'd1;
            state_q   <= RECEIVE;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
            if (to_cnt_q == TO_LAST) begin
              timeout_q <= 1'b1;
              pad_en_q  <= 1'b0;
              done_q    <= 1'b1;
              state_q   <= DONE;
            end
          end
        end
        RECEIVE: begin
          resp_q    <= resp_d;
          crc_q     <= crc_d;
          bit_cnt_q <= bit_cnt_q + 8'd1;
          if (bit_cnt_q == last_bit) begin
            crc_ok_q    <= crc_ok_d;
            frame_err_q <= frame_err_d;
            pad_en_q    <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pad_enable       = pad_en_q;
  assign pad_output_input = 1'b0;
  assign response         = resp_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign crc_ok           = crc_ok_q;
  assign frame_err        = frame_err_q;
  assign timeout          = timeout_q;

endmodule

// File: tb/tb_sd_cmd_response_rx.sv
// Scoreboard bench for sd_cmd_response_rx: stimulus pushes expected results,
// a monitor pops and compares them whenever done pulses.
module tb_sd_cmd_response_rx;

  logic         clock;
  logic         reset;
  logic         start;
  logic         long_resp;
  logic         serial_in;
  logic         pad_enable;
  logic         pad_output_input;
  logic [135:0] response;
  logic         busy;
  logic         done;
  logic         crc_ok;
  logic         frame_err;
  logic         timeout;

  sd_cmd_response_rx #(.TIMEOUT_CYCLES(64)) dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .long_resp        (long_resp),
    .serial_in        (serial_in),
    .pad_enable       (pad_enable),
    .pad_output_input (pad_output_input),
    .response         (response),
    .busy             (busy),
    .done             (done),
    .crc_ok           (crc_ok),
    .frame_err        (frame_err),
    .timeout          (timeout)
  );

  typedef struct {
    logic [135:0] resp;
    logic         crc_ok;
    logic         frame_err;
    logic         timeout;
    int           done_cyc;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;

  localparam logic [135:0] R7_OK   = 136'h08000001AA13;
  localparam logic [135:0] R7_CRC  = 136'h08000011AA13;
  localparam logic [135:0] R7_END  = 136'h08000001AA12;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Augmented-message long division, independent of the serial LFSR form.
  function automatic logic [6:0] crc7_ref(input logic [135:0] bits, input int n);
    logic [6:0] r;
    logic       top;
    logic       b;
    r = '0;
    for (int i = 0; i < n + 7; i++) begin
      b   = (i < n) ? bits[n-1-i] : 1'b0;
      top = r[6];
      r   = {r[5:0], b};
      if (top) r = r ^ 7'h09;
    end
    return r;
  endfunction

  // Monitor: every done pulse must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 136'(done), 136'(1'b0));
        end else begin
          e = sb.pop_front();
          check("response",   response,          e.resp);
          check("crc_ok",     136'(crc_ok),      136'(e.crc_ok));
          check("frame_err",  136'(frame_err),   136'(e.frame_err));
          check("timeout",    136'(timeout),     136'(e.timeout));
          check("done_cycle", 136'(cyc),         136'(e.done_cyc));
          @(negedge clock);
          check("done_pulse_len", 136'(done),       136'(1'b0));
          check("busy_after",     136'(busy),       136'(1'b0));
          check("pad_en_after",   136'(pad_enable), 136'(1'b0));
          check("resp_hold",      response,         e.resp);
        end
      end
    end
  end

  task automatic issue_start(input logic lng, output int c0);
    @(negedge clock);
    start     = 1'b1;
    long_resp = lng;
    c0        = cyc;
    @(negedge clock);
    start     = 1'b0;
    long_resp = ~lng;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 400 && sb.size() != 0; k++) @(negedge clock);
    if (sb.size() != 0) begin
      check("drain_budget", 136'(sb.size()), 136'(0));
      sb.delete();
    end
    repeat (3) @(negedge clock);
  endtask

  task automatic run_frame(input logic [135:0] f, input int n, input logic lng,
                           input logic exp_crc, input logic exp_fe,
                           input int pulse_at, input int abort_at, input logic start_in_done);
    int   c0;
    exp_t e;
    issue_start(lng, c0);
    serial_in = 1'b1;
    repeat (3) @(negedge clock);
    check("pad_en_wait", 136'(pad_enable), 136'(1'b1));
    check("busy_wait",   136'(busy),       136'(1'b1));
    check("pad_dir",     136'(pad_output_input), 136'(1'b0));
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (i == abort_at) begin
        reset = 1'b1;
        #1;
        check("rst_response", response, 136'(0));
        check("rst_ctrl", 136'({busy, done, pad_enable, pad_output_input}), 136'(0));
        check("rst_flags", 136'({crc_ok, frame_err, timeout}), 136'(0));
        @(negedge clock);
        reset     = 1'b0;
        serial_in = 1'b1;
        return;
      end
      if (i == 0 && abort_at < 0) begin
        e.resp      = f;
        e.crc_ok    = exp_crc;
        e.frame_err = exp_fe;
        e.timeout   = 1'b0;
        e.done_cyc  = cyc + n;
        sb.push_back(e);
      end
      start     = (i == pulse_at);
      serial_in = f[n-1-i];
    end
    @(negedge clock);
    serial_in = 1'b1;
    start     = start_in_done;
    @(negedge clock);
    start     = 1'b0;
    wait_drain();
  endtask

  task automatic run_timeout();
    int   c0;
    exp_t e;
    issue_start(1'b0, c0);
    serial_in   = 1'b1;
    e.resp      = '0;
    e.crc_ok    = 1'b0;
    e.frame_err = 1'b0;
    e.timeout   = 1'b1;
    e.done_cyc  = c0 + 66;
    sb.push_back(e);
    repeat (10) @(negedge clock);
    check("pad_en_timeout_wait", 136'(pad_enable), 136'(1'b1));
    wait_drain();
  endtask

  initial begin
    logic [119:0] r2_data;
    logic [135:0] r2;
    reset     = 1'b1;
    start     = 1'b0;
    long_resp = 1'b0;
    serial_in = 1'b1;
    repeat (3) @(negedge clock);
    check("reset_response", response, 136'(0));
    check("reset_ctrl", 136'({busy, done, pad_enable, pad_output_input}), 136'(0));
    check("reset_flags", 136'({crc_ok, frame_err, timeout}), 136'(0));
    reset = 1'b0;
    repeat (2) @(negedge clock);

    run_frame(R7_OK,  48, 1'b0, 1'b1, 1'b0, -1, -1, 1'b1);
    run_frame(R7_CRC, 48, 1'b0, 1'b0, 1'b0, -1, -1, 1'b0);
    run_frame(R7_END, 48, 1'b0, 1'b1, 1'b1, -1, -1, 1'b0);
    run_timeout();

    r2_data = 120'h1D414453_44323010_E2F1A5C3_0123AB;
    r2 = {2'b00, 6'b111111, r2_data, 7'h00, 1'b1};
    r2[7:1] = crc7_ref(r2, 128) ;
    r2[7:1] = crc7_ref({8'h00, r2[127:0]} >> 8, 120);
    run_frame(r2, 136, 1'b1, 1'b1, 1'b0, -1, -1, 1'b0);

    run_frame(R7_OK, 48, 1'b0, 1'b1, 1'b0, -1, 20, 1'b0);
    repeat (2) @(negedge clock);
    run_frame(R7_OK, 48, 1'b0, 1'b1, 1'b0, 10, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sd_cmd_response_rx.md
# sd_cmd_response_rx

Receives card responses on the SD CMD line through the host pad. After the command transmitter finishes sending a command, this block takes control of the CMD pad in input mode and waits for the card's start bit. It then shifts in a 48-bit (R1/R3/R6/R7) or 136-bit (R2) response frame, checks framing and CRC7, and reports the result to the host command FSM. Timeout applies if the card stays silent.

## Interface
- `TIMEOUT_CYCLES`, default 64: maximum number of sampled cycles spent waiting for a start bit (SD NCR limit).
- `clock` — in, 1: the single clock, SD clock domain.
- `reset` — in, 1: asynchronous, active-high reset.
- `start` — in, 1: one-cycle request to begin receiving; honoured only in IDLE.
- `long_resp` — in, 1: 1 = 136-bit R2 frame, 0 = 48-bit frame; captured when `start` is accepted.
- `serial_in` — in, 1: sampled CMD line, driven by the pad's `data_out`.
- `pad_enable` — out, 1: pad enable; 1 in WAIT_START and RECEIVE.
- `pad_output_input` — out, 1: pad direction; constant 0 (input).
- `response` — out, 136: received frame, MSB = first bit received. A 48-bit frame sits in [47:0] with [135:48] = 0.
- `busy` — out, 1: high in every state except IDLE.
- `done` — out, 1: one-cycle pulse at the end of a frame or on timeout.
- `crc_ok` — out, 1: CRC7 match; valid while `done`=1 and held afterwards.
- `frame_err` — out, 1: transmission bit ≠ 0 or end bit ≠ 1; valid and held like `crc_ok`.
- `timeout` — out, 1: no start bit seen within `TIMEOUT_CYCLES`; valid and held like `crc_ok`.

## Operation
- FSM states: IDLE, WARMUP, WAIT_START, RECEIVE, DONE.
- **IDLE**, on `start`=1:
  - latch `long_resp`;
  - clear `response`, `crc_ok`, `frame_err`, `timeout`, the timeout counter and CRC;
  - go to WARMUP.
  - `start` in any other state is ignored.
- **WARMUP**, one cycle: `pad_enable`=1 and `serial_in` is ignored, because the pad's input register has one cycle of latency. Go to WAIT_START.
- **WAIT_START**:
  - `serial_in`=0 is the start bit: shift it into `response` bit 0 (shift-left register), set bit counter = 1, go to RECEIVE.
  - Otherwise increment the timeout counter. When it reaches `TIMEOUT_CYCLES`: set `timeout`=1 and go to DONE.
- **RECEIVE**:
  - Shift one bit per cycle; increment the counter.
  - Leave when counter = 48 (short) or 136 (long).
- **CRC7** uses polynomial x^7+x^3+1, initial value 0, MSB-first, serial update.
  - Short frame: covers frame bits 47..8 (40 bits); compared against bits 7..1.
  - Long frame: covers bits 127..8 (120 bits); compared against bits 7..1. Bits 135..128 are excluded.
- **Framing check**: `frame_err` = (bit N-2 ≠ 0) or (bit 0 ≠ 1), where N = 48 or 136.
- **DONE**:
  - `done`=1 for one cycle; flags and `response` become valid.
  - `pad_enable` returns to 0.
  - Go to IDLE. Outputs hold until the next accepted `start`.
- R3 carries no valid CRC. `crc_ok` is still reported, and the host ignores it for R3.
- **Reset** (any time, including mid-frame):
  - state = IDLE;
  - `response`=0 and all flags = 0;
  - `busy`=`done`=`pad_enable`=0 and `pad_output_input`=0;
  - counters and CRC = 0.

## Timing
- `start` is sampled at edge T0. WARMUP occupies T1, and WAIT_START samples from T2.
- Start bit sampled at Ts → 48-bit frame: last bit at Ts+47, `done` at Ts+48. 136-bit frame: `done` at Ts+136.
- Line stays high → `done` and `timeout` at T2+`TIMEOUT_CYCLES`. `busy` falls one cycle after `done`.
- `busy` rises the cycle after `start` is accepted and stays high through DONE.
- `start` asserted in the same cycle as DONE is ignored; the next `start` is accepted in IDLE.
- The counters fit in ceil(log2) widths: 8 bits for the bit count and 8 bits for the timeout counter at the default.

## Test plan
- **R7 short frame.** `start`, `long_resp`=0, then stream 48'h08000001AA13 after 3 idle-high cycles → `done` 48 cycles after the start bit, `response`[47:0]=48'h08000001AA13, `crc_ok`=1, `frame_err`=0, `timeout`=0.
- **Corrupted CRC.** Same frame with bit 20 flipped → `crc_ok`=0, `frame_err`=0, `response` shows the flipped bit.
- **Bad end bit.** Frame 48'h08000001AA12 → `frame_err`=1, `crc_ok`=1.
- **Timeout.** `start` with line held 1 → `done`=`timeout`=1 exactly 64 cycles after WAIT_START entry; `busy` then 0 and `pad_enable`=0.
- **R2 long frame.** `long_resp`=1; frame = start 0, trans 0, 6'b111111, 120 data bits, valid CRC7, end 1 → `done` at Ts+136, `crc_ok`=1, `response` equals the frame.
- **Reset mid-frame.** Assert `reset` at bit 20 of RECEIVE → all outputs 0 immediately. After release, a new `start` plus a valid R7 frame completes normally; a `start` pulse during RECEIVE has no effect.
